// File: rtl/multicyc_ctrl_unit_if.sv
// Datapath-facing bundle of the multi-cycle MIPS control unit: instruction fields,
// memory handshake and every datapath enable/select the controller drives.
interface multicyc_ctrl_unit_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic [5:0]       iOpCode;
  logic [5:0]       iFunct;
  logic             iAluZero;
  logic             iMemReady;

  logic             oPCWrite;
  logic             oIRWrite;
  logic             oMDRWrite;
  logic             oRegWrite;
  logic             oMemRead;
  logic             oMemWrite;
  logic             oIorD;
  logic             oExtZero;
  logic [1:0]       oALUSrcA;
  logic [1:0]       oALUSrcB;
  logic [2:0]       oALUOp;
  logic [1:0]       oPCSource;
  logic [1:0]       oRegDst;
  logic [1:0]       oMemtoReg;
  logic             oIllegal;
  logic             oMemErr;
  logic             oHalted;
  logic [CNT_W-1:0] oRetired;

  modport master (
    input  iOpCode, iFunct, iAluZero, iMemReady,
    output oPCWrite, oIRWrite, oMDRWrite, oRegWrite, oMemRead, oMemWrite, oIorD, oExtZero,
           oALUSrcA, oALUSrcB, oALUOp, oPCSource, oRegDst, oMemtoReg,
           oIllegal, oMemErr, oHalted, oRetired
  );

  modport slave (
    output iOpCode, iFunct, iAluZero, iMemReady,
    input  oPCWrite, oIRWrite, oMDRWrite, oRegWrite, oMemRead, oMemWrite, oIorD, oExtZero,
           oALUSrcA, oALUSrcB, oALUOp, oPCSource, oRegDst, oMemtoReg,
           oIllegal, oMemErr, oHalted, oRetired
  );

endinterface

// File: rtl/multicyc_ctrl_unit.sv
// Multi-cycle MIPS control FSM: sequences each instruction over a shared ALU and one
// memory port, with a ready handshake, optional access timeout and a retired counter.
module multicyc_ctrl_unit #(
  parameter int unsigned MEM_TIMEOUT     = 0,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input logic                  iClk,
  input logic                  iRst_n,
  multicyc_ctrl_unit_if.master ctrl_bus
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAddr,
    StMemLw,
    StMemWb,
    StMemSw,
    StRExec,
    StRWb,
    StIExec,
    StIWb,
    StBranch,
    StJump,
    StJr,
    StTrap
  } state_e;

  state_e           state_q, state_d, dec_state;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             dec_illegal, mem_wait, retire;

  logic [5:0] op, funct;
  logic       ready, zero;

  assign op    = ctrl_bus.iOpCode;
  assign funct = ctrl_bus.iFunct;
  assign ready = ctrl_bus.iMemReady;
  assign zero  = ctrl_bus.iAluZero;

  // Instruction dispatch out of DECODE.
  always_comb begin
    dec_state   = TRAP_ON_ILLEGAL ? StTrap : StFetch;
    dec_illegal = 1'b1;
    if (op inside {OpLw, OpSw}) begin
      dec_state   = StMemAddr;
      dec_illegal = 1'b0;
    end else if (op == OpRType && funct inside {FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr,
                                                FnXor, FnNor, FnSll, FnSrl, FnSra, FnSlt}) begin
      dec_state   = StRExec;
      dec_illegal = 1'b0;
    end else if (op == OpRType && funct inside {FnJr, FnJalr}) begin
      dec_state   = StJr;
      dec_illegal = 1'b0;
    end else if (op inside {OpAddi, OpAddiu, OpAndi, OpSlti, OpSltiu, OpLui}) begin
      dec_state   = StIExec;
      dec_illegal = 1'b0;
    end else if (op inside {OpBeq, OpBne}) begin
      dec_state   = StBranch;
      dec_illegal = 1'b0;
    end else if (op inside {OpJ, OpJal}) begin
      dec_state   = StJump;
      dec_illegal = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_wait  = 1'b0;
    mem_err_d = mem_err_q;
    unique case (state_q)
      StFetch:   if (ready) state_d = StDecode; else mem_wait = 1'b1;
      StDecode:  state_d = dec_state;
      StMemAddr: state_d = (op == OpLw) ? StMemLw : StMemSw;
      StMemLw:   if (ready) state_d = StMemWb; else mem_wait = 1'b1;
      StMemSw:   if (ready) state_d = StFetch; else mem_wait = 1'b1;
      StRExec:   state_d = StRWb;
      StIExec:   state_d = StIWb;
      StMemWb, StRWb, StIWb, StBranch, StJump, StJr: state_d = StFetch;
      StTrap:    state_d = StTrap;
      default:   state_d = StFetch;
    endcase

    // Ready in the limit cycle has already completed the access above.
    if (MEM_TIMEOUT > 0 && mem_wait && wait_q == WaitW'(MEM_TIMEOUT)) begin
      state_d   = StTrap;
      mem_err_d = 1'b1;
    end

    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_wait) begin
      wait_d = wait_q + WaitW'(1);
    end else begin
      wait_d = wait_q;
    end

    retire    = (state_d == StFetch) &&
                (state_q inside {StMemWb, StMemSw, StRWb, StIWb, StBranch, StJump, StJr});
    retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      retired_q <= retired_d;
    end
  end

  logic       pc_write, ir_write, mdr_write, reg_write, mem_read, mem_write, iord, ext_zero;
  logic [1:0] alu_src_a, alu_src_b, pc_source, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic       illegal, halted;

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ext_zero   = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 3'd0;
    pc_source  = 2'd0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    illegal    = 1'b0;
    halted     = 1'b0;
    // Reset forces every output low, including mid-access.
    if (iRst_n) begin
      unique case (state_q)
        StFetch: begin
          mem_read = 1'b1;
          if (ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'd1;
          end
        end
        StDecode: begin
          alu_src_b = 2'd3;
          illegal   = dec_illegal;
        end
        StMemAddr: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
        end
        StMemLw: begin
          mem_read  = 1'b1;
          iord      = 1'b1;
          mdr_write = ready;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
        end
        StMemSw: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        StRExec: begin
          alu_src_a = (funct inside {FnSll, FnSrl, FnSra}) ? 2'd2 : 2'd1;
          alu_op    = 3'd2;
        end
        StRWb: begin
          reg_write = 1'b1;
          reg_dst   = 2'd1;
        end
        StIExec: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
          ext_zero  = (op == OpAndi);
          case (op)
            OpAndi:  alu_op = 3'd3;
            OpSlti:  alu_op = 3'd4;
            OpSltiu: alu_op = 3'd5;
            OpLui:   alu_op = 3'd6;
            default: alu_op = 3'd0;
          endcase
        end
        StIWb: reg_write = 1'b1;
        StBranch: begin
          alu_src_a = 2'd1;
          alu_op    = 3'd1;
          pc_source = 2'd1;
          pc_write  = (op == OpBne) ? ~zero : zero;
        end
        StJump: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
          if (op == OpJal) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
          end
        end
        StJr: begin
          pc_write  = 1'b1;
          pc_source = 2'd3;
          if (funct == FnJalr) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd1;
            mem_to_reg = 2'd2;
          end
        end
        StTrap:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign ctrl_bus.oPCWrite  = pc_write;
  assign ctrl_bus.oIRWrite  = ir_write;
  assign ctrl_bus.oMDRWrite = mdr_write;
  assign ctrl_bus.oRegWrite = reg_write;
  assign ctrl_bus.oMemRead  = mem_read;
  assign ctrl_bus.oMemWrite = mem_write;
  assign ctrl_bus.oIorD     = iord;
  assign ctrl_bus.oExtZero  = ext_zero;
  assign ctrl_bus.oALUSrcA  = alu_src_a;
  assign ctrl_bus.oALUSrcB  = alu_src_b;
  assign ctrl_bus.oALUOp    = alu_op;
  assign ctrl_bus.oPCSource = pc_source;
  assign ctrl_bus.oRegDst   = reg_dst;
  assign ctrl_bus.oMemtoReg = mem_to_reg;
  assign ctrl_bus.oIllegal  = illegal;
  assign ctrl_bus.oHalted   = halted;
  assign ctrl_bus.oMemErr   = iRst_n & mem_err_q;
  assign ctrl_bus.oRetired  = iRst_n ? retired_q : '0;

endmodule

// File: tb/tb_multicyc_ctrl_unit.sv
// Directed bench for multicyc_ctrl_unit: four instances cover the default build,
// illegal-as-NOP, a 5-cycle memory timeout and a 4-bit retired counter.
module tb_multicyc_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n, rst_c_n, rst_d_n;
  logic [5:0] op, funct;
  logic       zero, ready;
  int unsigned n_asserts = 0;
  int unsigned n_fails   = 0;

  multicyc_ctrl_unit_if #(.CNT_W(32)) bus_a ();
  multicyc_ctrl_unit_if #(.CNT_W(32)) bus_b ();
  multicyc_ctrl_unit_if #(.CNT_W(32)) bus_c ();
  multicyc_ctrl_unit_if #(.CNT_W(4))  bus_d ();

  assign bus_a.iOpCode = op;    assign bus_a.iFunct = funct;
  assign bus_a.iAluZero = zero; assign bus_a.iMemReady = ready;
  assign bus_b.iOpCode = op;    assign bus_b.iFunct = funct;
  assign bus_b.iAluZero = zero; assign bus_b.iMemReady = ready;
  assign bus_c.iOpCode = op;    assign bus_c.iFunct = funct;
  assign bus_c.iAluZero = zero; assign bus_c.iMemReady = ready;
  assign bus_d.iOpCode = op;    assign bus_d.iFunct = funct;
  assign bus_d.iAluZero = zero; assign bus_d.iMemReady = ready;

  multicyc_ctrl_unit #(.MEM_TIMEOUT(0), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)) u_dut_a (
    .iClk(clk), .iRst_n(rst_a_n), .ctrl_bus(bus_a.master)
  );
  multicyc_ctrl_unit #(.MEM_TIMEOUT(0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(32)) u_dut_b (
    .iClk(clk), .iRst_n(rst_b_n), .ctrl_bus(bus_b.master)
  );
  multicyc_ctrl_unit #(.MEM_TIMEOUT(5), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)) u_dut_c (
    .iClk(clk), .iRst_n(rst_c_n), .ctrl_bus(bus_c.master)
  );
  multicyc_ctrl_unit #(.MEM_TIMEOUT(0), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(4)) u_dut_d (
    .iClk(clk), .iRst_n(rst_d_n), .ctrl_bus(bus_d.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle, drive ready for it, let outputs settle.
  task automatic step(input logic r);
    @(negedge clk);
    ready = r;
    #1;
  endtask

  function automatic logic [31:0] pack_a();
    return {8'h00, bus_a.oPCWrite, bus_a.oIRWrite, bus_a.oMDRWrite, bus_a.oRegWrite,
            bus_a.oMemRead, bus_a.oMemWrite, bus_a.oIorD, bus_a.oExtZero,
            bus_a.oALUSrcA, bus_a.oALUSrcB, bus_a.oALUOp, bus_a.oPCSource,
            bus_a.oRegDst, bus_a.oMemtoReg, bus_a.oIllegal, bus_a.oMemErr, bus_a.oHalted};
  endfunction

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0; rst_d_n = 1'b0;
    op = 6'h00; funct = 6'h20; zero = 1'b0; ready = 1'b1;

    // ---- default build: reset then add
    step(1'b1);
    chk("rst_outs_0", pack_a(), 32'h0);
    chk("rst_retired_0", bus_a.oRetired, 32'd0);
    step(1'b1);
    chk("rst_outs_1", pack_a(), 32'h0);
    rst_a_n = 1'b1;
    #1;
    chk("add_fetch_memrd", bus_a.oMemRead, 32'd1);
    chk("add_fetch_irw", bus_a.oIRWrite, 32'd1);
    chk("add_fetch_pcw", bus_a.oPCWrite, 32'd1);
    chk("add_fetch_srcb", bus_a.oALUSrcB, 32'd1);
    chk("add_fetch_iord", bus_a.oIorD, 32'd0);
    step(1'b1);
    chk("add_dec_srcb", bus_a.oALUSrcB, 32'd3);
    chk("add_dec_memrd", bus_a.oMemRead, 32'd0);
    step(1'b1);
    chk("add_rexec_srca", bus_a.oALUSrcA, 32'd1);
    chk("add_rexec_aluop", bus_a.oALUOp, 32'd2);
    step(1'b1);
    chk("add_rwb_regw", bus_a.oRegWrite, 32'd1);
    chk("add_rwb_regdst", bus_a.oRegDst, 32'd1);
    chk("add_rwb_retired", bus_a.oRetired, 32'd0);

    // ---- lw with three wait cycles in MEM_LW
    op = 6'h23;
    step(1'b1);
    chk("lw_fetch_retired", bus_a.oRetired, 32'd1);
    step(1'b1);
    step(1'b1);
    chk("lw_addr_srca", bus_a.oALUSrcA, 32'd1);
    chk("lw_addr_srcb", bus_a.oALUSrcB, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk("lw_wait_rd_iord", {bus_a.oMemRead, bus_a.oIorD}, 32'd3);
      chk("lw_wait_mdrw", bus_a.oMDRWrite, 32'd0);
    end
    step(1'b1);
    chk("lw_rdy_rd_iord", {bus_a.oMemRead, bus_a.oIorD}, 32'd3);
    chk("lw_rdy_mdrw", bus_a.oMDRWrite, 32'd1);
    step(1'b1);
    chk("lw_wb_regw", bus_a.oRegWrite, 32'd1);
    chk("lw_wb_memtoreg", bus_a.oMemtoReg, 32'd1);
    chk("lw_wb_mdrw", bus_a.oMDRWrite, 32'd0);

    // ---- beq taken, then bne not taken, both with zero=1
    op = 6'h04; zero = 1'b1;
    step(1'b1);
    chk("beq_fetch_retired", bus_a.oRetired, 32'd2);
    step(1'b1);
    step(1'b1);
    chk("beq_br_pcw", bus_a.oPCWrite, 32'd1);
    chk("beq_br_pcsrc", bus_a.oPCSource, 32'd1);
    chk("beq_br_aluop", bus_a.oALUOp, 32'd1);
    op = 6'h05;
    step(1'b1);
    chk("bne_fetch_retired", bus_a.oRetired, 32'd3);
    step(1'b1);
    step(1'b1);
    chk("bne_br_pcw", bus_a.oPCWrite, 32'd0);

    // ---- jal, then jalr
    op = 6'h03;
    step(1'b1);
    chk("jal_fetch_retired", bus_a.oRetired, 32'd4);
    step(1'b1);
    step(1'b1);
    chk("jal_pcw_pcsrc", {bus_a.oPCWrite, bus_a.oPCSource}, 32'h6);
    chk("jal_regw_dst_m2r", {bus_a.oRegWrite, bus_a.oRegDst, bus_a.oMemtoReg}, 32'h1A);
    op = 6'h00; funct = 6'h09;
    step(1'b1);
    chk("jalr_fetch_retired", bus_a.oRetired, 32'd5);
    step(1'b1);
    step(1'b1);
    chk("jalr_pcw_pcsrc", {bus_a.oPCWrite, bus_a.oPCSource}, 32'h7);
    chk("jalr_regw_dst_m2r", {bus_a.oRegWrite, bus_a.oRegDst, bus_a.oMemtoReg}, 32'h16);

    // ---- andi, then sw
    op = 6'h0C;
    step(1'b1);
    chk("andi_fetch_retired", bus_a.oRetired, 32'd6);
    step(1'b1);
    step(1'b1);
    chk("andi_exec_aluop", bus_a.oALUOp, 32'd3);
    chk("andi_exec_extzero", bus_a.oExtZero, 32'd1);
    step(1'b1);
    chk("andi_wb_regw_dst", {bus_a.oRegWrite, bus_a.oRegDst}, 32'h4);
    op = 6'h2B;
    step(1'b1);
    chk("sw_fetch_retired", bus_a.oRetired, 32'd7);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("sw_mem_wr_iord", {bus_a.oMemWrite, bus_a.oIorD, bus_a.oMemRead}, 32'h6);

    // ---- illegal opcode traps
    op = 6'h3F;
    step(1'b1);
    chk("ill_fetch_retired", bus_a.oRetired, 32'd8);
    step(1'b1);
    chk("ill_dec_pulse", bus_a.oIllegal, 32'd1);
    step(1'b1);
    chk("ill_trap_halted", bus_a.oHalted, 32'd1);
    chk("ill_trap_pulse_gone", bus_a.oIllegal, 32'd0);
    step(1'b1);
    chk("ill_trap_stays", {bus_a.oHalted, bus_a.oMemRead}, 32'h2);
    chk("ill_trap_retired", bus_a.oRetired, 32'd8);
    rst_a_n = 1'b0;
    #1;
    chk("rst_again_outs", pack_a(), 32'h0);
    step(1'b1);
    chk("rst_again_retired", bus_a.oRetired, 32'd0);

    // ---- illegal as NOP
    op = 6'h3F;
    step(1'b1);
    step(1'b1);
    rst_b_n = 1'b1;
    #1;
    chk("nop_fetch_memrd", bus_b.oMemRead, 32'd1);
    step(1'b1);
    chk("nop_dec_pulse", bus_b.oIllegal, 32'd1);
    step(1'b1);
    chk("nop_back_fetch", {bus_b.oMemRead, bus_b.oHalted, bus_b.oIllegal}, 32'h4);
    chk("nop_not_retired", bus_b.oRetired, 32'd0);

    // ---- memory timeout of 5
    op = 6'h00; funct = 6'h20;
    step(1'b0);
    step(1'b0);
    rst_c_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b0);
      chk("to_wait_rd_err_halt", {bus_c.oMemRead, bus_c.oMemErr, bus_c.oHalted}, 32'h4);
    end
    step(1'b0);
    chk("to_err_halt", {bus_c.oMemRead, bus_c.oMemErr, bus_c.oHalted}, 32'h3);
    step(1'b0);
    chk("to_err_sticky", {bus_c.oMemErr, bus_c.oHalted}, 32'h3);
    rst_c_n = 1'b0;
    step(1'b0);
    rst_c_n = 1'b1;
    #1;
    chk("to_rst_clears", {bus_c.oMemRead, bus_c.oMemErr, bus_c.oHalted}, 32'h4);
    for (int i = 0; i < 4; i++) step(1'b0);
    step(1'b1);
    chk("to_ready_wins_irw", {bus_c.oIRWrite, bus_c.oMemErr}, 32'h2);
    step(1'b1);
    chk("to_ready_wins_dec", {bus_c.oALUSrcB, bus_c.oMemErr, bus_c.oHalted}, 32'hC);

    // ---- 4-bit counter wraps after 16 branches
    op = 6'h04; zero = 1'b1;
    step(1'b1);
    step(1'b1);
    rst_d_n = 1'b1;
    #1;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1);
      step(1'b1);
      step(1'b1);
      chk("wrap_retired", 32'(bus_d.oRetired), 32'(k % 16));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/multicyc_ctrl_unit.md
# multicyc_ctrl_unit

Parametrised multi-cycle control FSM for the MIPS core, successor to the single-cycle opcode decoder. It sequences each instruction over several clocks on a shared ALU and a single memory port. Memory accesses use a ready handshake with a configurable timeout. The block decodes illegal instructions and counts retired instructions.

## Interface
- `MEM_TIMEOUT`, default 0: wait-cycle limit per memory access. 0 disables the timeout.
- `TRAP_ON_ILLEGAL`, default 1: 1 sends an illegal instruction to TRAP; 0 executes it as a NOP.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `iClk` in 1: clock; all state changes on the rising edge.
- `iRst_n` in 1: reset, synchronous and active-low.
- `iOpCode` in 6: instruction bits [31:26]. Valid from DECODE onward.
- `iFunct` in 6: instruction bits [5:0].
- `iAluZero` in 1: ALU zero flag.
- `iMemReady` in 1: memory access completes on the edge where this is 1.
- `oPCWrite` `oIRWrite` `oMDRWrite` `oRegWrite` `oMemRead` `oMemWrite` `oIorD` `oExtZero` out 1 each: datapath enables/selects.
- `oALUSrcA` out 2: 0 PC, 1 regA, 2 shamt.
- `oALUSrcB` out 2: 0 regB, 1 const 4, 2 ext imm, 3 ext imm<<2.
- `oALUOp` out 3: 0 add, 1 sub, 2 funct-decoded, 3 and, 4 slt, 5 sltu, 6 lui.
- `oPCSource` out 2: 0 ALU result, 1 ALUOut reg, 2 jump target, 3 regA.
- `oRegDst` out 2: 0 rt, 1 rd, 2 $31.
- `oMemtoReg` out 2: 0 ALUOut, 1 MDR, 2 PC.
- `oIllegal` out 1: one-cycle pulse on an illegal instruction.
- `oMemErr` out 1: sticky; set on memory timeout.
- `oHalted` out 1: high in TRAP.
- `oRetired` out CNT_W: retired-instruction count.

## Operation
**Outputs**
- All outputs are decoded from the state register, plus `iMemReady`, `iAluZero` and the opcode where noted.
- Any output not listed for a state is 0.

**States**
- FETCH
  - Drives `oMemRead`=1, `oIorD`=0.
  - On `iMemReady`=1: `oIRWrite`=1 and `oPCWrite`=1 with SrcA=0, SrcB=1, ALUOp=0, PCSource=0 (PC<=PC+4). Next state is DECODE.
  - Otherwise stays in FETCH.
- DECODE
  - SrcA=0, SrcB=3, ALUOp=0 (branch target to ALUOut).
  - Dispatch:
    - lw/sw: MEM_ADDR.
    - R-type (funct add, addu, sub, subu, and, or, xor, nor, sll, srl, sra, slt): R_EXEC.
    - jr/jalr: JR.
    - addi, addiu, andi, slti, sltiu, lui: I_EXEC.
    - beq/bne: BRANCH.
    - j/jal: JUMP.
  - Anything else: `oIllegal`=1, then TRAP if `TRAP_ON_ILLEGAL`, else FETCH.
- MEM_ADDR
  - SrcA=1, SrcB=2, ALUOp=0.
  - Next state is MEM_LW or MEM_SW.
- MEM_LW
  - `oMemRead`=1, `oIorD`=1.
  - On ready: `oMDRWrite`=1, next state MEM_WB.
- MEM_WB
  - `oRegWrite`=1, RegDst=0, MemtoReg=1.
  - Next state FETCH.
- MEM_SW
  - `oMemWrite`=1, `oIorD`=1.
  - On ready: next state FETCH.
- R_EXEC
  - SrcA=2 for sll/srl/sra, else 1. SrcB=0, ALUOp=2.
- R_WB
  - `oRegWrite`=1, RegDst=1, MemtoReg=0.
- I_EXEC
  - SrcA=1, SrcB=2.
  - ALUOp by opcode: addi/addiu 0, andi 3, slti 4, sltiu 5, lui 6.
  - `oExtZero`=1 for andi only.
- I_WB
  - `oRegWrite`=1, RegDst=0, MemtoReg=0.
- BRANCH
  - SrcA=1, SrcB=0, ALUOp=1, PCSource=1.
  - `oPCWrite` = `iAluZero` for beq, `~iAluZero` for bne.
- JUMP
  - `oPCWrite`=1, PCSource=2.
  - jal also drives `oRegWrite`=1, RegDst=2, MemtoReg=2. The PC register already holds PC+4 at this point.
- JR
  - `oPCWrite`=1, PCSource=3.
  - jalr also drives `oRegWrite`=1, RegDst=1, MemtoReg=2.
- TRAP
  - All enables 0, `oHalted`=1.
  - Exits only on reset.
- Sequencing: R_EXEC goes to R_WB, and I_EXEC to I_WB. MEM_WB, R_WB, I_WB, BRANCH, JUMP and JR go to FETCH.

**Retired counter**
- Increments on each transition into FETCH from MEM_WB, MEM_SW, R_WB, I_WB, BRANCH, JUMP or JR.
- Illegal NOPs are not counted.
- Wraps modulo 2^CNT_W.

**Timeout**
- A wait counter clears on entry to FETCH, MEM_LW and MEM_SW.
- It increments every cycle the state is waiting with `iMemReady`=0.
- If `MEM_TIMEOUT`>0 and the counter equals `MEM_TIMEOUT` while `iMemReady`=0: set `oMemErr` and go to TRAP.
- If `iMemReady`=1 in the same cycle the limit is reached, the access completes normally.

## Timing
**Reset**
- `iRst_n` low at an edge: state becomes FETCH, and counters, `oMemErr` and `oRetired` become 0.
- While `iRst_n` is low, every output is forced to 0.
- The first cycle after release shows `oMemRead`=1.

**Latency** (zero wait states)
- branch and j/jal/jr/jalr: 3 cycles.
- R-type, I-type and sw: 4 cycles.
- lw: 5 cycles.
- Each memory wait cycle adds 1.

**Handshake**
- Request outputs stay asserted until ready is sampled.
- Ready outside FETCH, MEM_LW or MEM_SW is ignored.

**Other boundaries**
- Reset mid-access aborts the access with no write enables.
- Simultaneous timeout-limit and ready: ready wins.

## Test plan
- `iRst_n`=0 for 2 edges then 1, `iMemReady`=1, opcode 0x00 funct 0x20 (add):
  - Outputs are all 0 during reset.
  - Then FETCH, DECODE, R_EXEC, R_WB (`oRegWrite`=1, RegDst=1).
  - `oRetired`=1 after 4 cycles.
- lw (0x23) with `iMemReady` low for 3 cycles in MEM_LW:
  - `oMemRead` and `oIorD` held for 4 cycles.
  - `oMDRWrite` asserted once.
  - Total 8 cycles.
- beq with `iAluZero`=1, then bne with `iAluZero`=1:
  - beq: `oPCWrite`=1 in BRANCH.
  - bne: `oPCWrite`=0 in BRANCH.
  - Each takes 3 cycles.
- jal (0x03): in JUMP, `oPCWrite`=1, PCSource=2, `oRegWrite`=1, RegDst=2, MemtoReg=2.
  - Same check for jalr (funct 0x09) in JR with PCSource=3.
- Opcode 0x3F:
  - `TRAP_ON_ILLEGAL`=1: `oIllegal` pulses, `oHalted`=1 persists, and `oRetired` does not change.
  - `TRAP_ON_ILLEGAL`=0: returns to FETCH.
- `MEM_TIMEOUT`=5 with `iMemReady` held 0 in FETCH:
  - `oMemErr` and `oHalted` set on the 6th cycle.
  - Reset clears both.
- `CNT_W`=4 with 16 retired instructions: `oRetired` wraps to 0.
